// File: rtl/jtag_types_pkg.sv
// Shared JTAG debug-path types: AP shift register layout,
// AHB encodings and the AP controller state machine.
package jtag_types_pkg;

    typedef enum logic {
        REG_ADDRESS = 1'b0,
        REG_DATA    = 1'b1
    } regselect_t;

    typedef enum logic {
        AP_READ  = 1'b0,
        AP_WRITE = 1'b1
    } r_w_t;

    typedef enum logic [1:0] {
        HSIZE_BYTE = 2'b00,
        HSIZE_HALF = 2'b01,
        HSIZE_WORD = 2'b10,
        HSIZE_RSVD = 2'b11
    } hsize_t;

    typedef struct packed {
        logic [31:0] data;
        regselect_t  regselect;
        hsize_t      size;
        logic        addrinc;
        r_w_t        r_w;
    } ap_shift_t;

    typedef enum logic [2:0] {
        AP_IDLE,
        AP_ADDR,
        AP_DATA,
        AP_ERR2,
        AP_RESP
    } ap_state_t;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_NONSEQ = 2'b10
    } htrans_t;

    // Natural alignment check for a transfer of the given size.
    function automatic logic misaligned(hsize_t size, logic [1:0] addr_lo);
        case (size)
            HSIZE_HALF: return addr_lo[0];
            HSIZE_WORD: return addr_lo != 2'b00;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ahb_ap_controller_lane_steer.sv
// Byte-lane steering: write-data replication and read-lane
// extraction with zero extension.
module ahb_lane_steer
    import jtag_types_pkg::*;
(
    input  hsize_t      size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [31:0] hwdata,
    output logic [31:0] rdata_ext
);

    logic [31:0] rshift;

    // Replicate the active lane on writes, right-align it on reads.
    always_comb begin
        rshift    = rdata >> {addr_lo, 3'b000};
        hwdata    = wdata;
        rdata_ext = rdata;
        case (size)
            HSIZE_BYTE: begin
                hwdata    = {4{wdata[7:0]}};
                rdata_ext = {24'h0, rshift[7:0]};
            end
            HSIZE_HALF: begin
                hwdata    = {2{wdata[15:0]}};
                rdata_ext = {16'h0, rshift[15:0]};
            end
            default: begin
                hwdata    = wdata;
                rdata_ext = rdata;
            end
        endcase
    end

endmodule

// File: rtl/ahb_ap_controller.sv
// Single-transfer AHB-Lite master driven by JTAG AP commands.
// Owns the AP address register, auto-increment and sticky error.
module ahb_ap_controller
    import jtag_types_pkg::*;
#(
    parameter logic [31:0] ADDR_RESET = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        cmd_valid,
    input  ap_shift_t   cmd,
    output logic        cmd_ready,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic        err_sticky,
    input  logic        err_clear,
    output logic [31:0] HADDR,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [1:0]  HTRANS,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP
);

    ap_state_t   state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    hsize_t      size_q, size_d;
    logic        inc_q, inc_d;
    r_w_t        rw_q, rw_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic        rsp_err_q, rsp_err_d;
    logic        err_sticky_q, err_sticky_d;
    logic        err_set;
    logic [31:0] lane_wdata;
    logic [31:0] lane_rdata;

    ahb_lane_steer u_steer (
        .size      (size_q),
        .addr_lo   (addr_q[1:0]),
        .wdata     (wdata_q),
        .rdata     (HRDATA),
        .hwdata    (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    // State and datapath registers; reset aborts any transfer.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= AP_IDLE;
            addr_q       <= ADDR_RESET;
            wdata_q      <= 32'h0;
            size_q       <= HSIZE_BYTE;
            inc_q        <= 1'b0;
            rw_q         <= AP_READ;
            rsp_data_q   <= 32'h0;
            rsp_err_q    <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            inc_q        <= inc_d;
            rw_q         <= rw_d;
            rsp_data_q   <= rsp_data_d;
            rsp_err_q    <= rsp_err_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Next-state and datapath updates for each controller state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        size_d     = size_q;
        inc_d      = inc_q;
        rw_d       = rw_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        err_set    = 1'b0;
        case (state_q)
            AP_IDLE: begin
                if (cmd_valid) begin
                    wdata_d = cmd.data;
                    size_d  = cmd.size;
                    inc_d   = cmd.addrinc;
                    rw_d    = cmd.r_w;
                    state_d = AP_RESP;
                    if (cmd.regselect == REG_ADDRESS) begin
                        rsp_err_d = 1'b0;
                        if (cmd.r_w == AP_WRITE) begin
                            addr_d = cmd.data;
                        end else begin
                            rsp_data_d = addr_q;
                        end
                    end else if (err_sticky_q) begin
                        rsp_err_d = 1'b1;
                    end else if (cmd.size == HSIZE_RSVD ||
                                 misaligned(cmd.size, addr_q[1:0])) begin
                        rsp_err_d = 1'b1;
                        err_set   = 1'b1;
                    end else begin
                        rsp_err_d = 1'b0;
                        state_d   = AP_ADDR;
                    end
                end
            end
            AP_ADDR: begin
                if (HREADY) begin
                    state_d = AP_DATA;
                end
            end
            AP_DATA: begin
                if (HREADY && !HRESP) begin
                    state_d = AP_RESP;
                    if (rw_q == AP_READ) begin
                        rsp_data_d = lane_rdata;
                    end
                    if (inc_q) begin
                        addr_d = addr_q + (32'd1 << size_q);
                    end
                end else if (HRESP) begin
                    // A one-cycle error response is still treated as an error.
                    if (HREADY) begin
                        err_set   = 1'b1;
                        rsp_err_d = 1'b1;
                        state_d   = AP_RESP;
                    end else begin
                        state_d = AP_ERR2;
                    end
                end
            end
            AP_ERR2: begin
                if (HREADY) begin
                    err_set   = 1'b1;
                    rsp_err_d = 1'b1;
                    state_d   = AP_RESP;
                end
            end
            AP_RESP: begin
                state_d = AP_IDLE;
            end
            default: begin
                state_d = AP_IDLE;
            end
        endcase
        err_sticky_d = err_clear ? 1'b0 : (err_sticky_q | err_set);
    end

    // Handshake and AHB outputs decoded from the current state.
    always_comb begin
        cmd_ready = (state_q == AP_IDLE);
        rsp_valid = (state_q == AP_RESP);
        HTRANS    = HTRANS_IDLE;
        HADDR     = 32'h0;
        HWRITE    = 1'b0;
        HSIZE     = 3'b000;
        HWDATA    = 32'h0;
        if (state_q == AP_ADDR) begin
            HTRANS = HTRANS_NONSEQ;
            HADDR  = addr_q;
            HWRITE = (rw_q == AP_WRITE);
            HSIZE  = {1'b0, size_q};
        end
        if (state_q == AP_DATA && rw_q == AP_WRITE) begin
            HWDATA = lane_wdata;
        end
    end

    assign rsp_data   = rsp_data_q;
    assign rsp_err    = rsp_err_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: doc/ahb_ap_controller.md
Name: ahb_ap_controller

Overview:
- Sequences single AHB-Lite master transfers from access-port commands (ap_shift_t) issued by the JTAG AHB scan chain after UPDATE_DR. Commands arrive already synchronised into the bus clock domain.
- Owns the AP address register, address auto-increment, byte-lane steering and a sticky bus-error flag. The error flag backs the AHB_ERROR instruction.
- Sits between the TAP-side AP shift register and the SoC AHB-Lite fabric; it is the only bus master driven by the debug path.

Parameters:
- ADDR_RESET, 32'h0000_0000, reset value of the AP address register.

Ports:
- CLK  in  1  bus clock; single clock domain.
- RST  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd  in  37  ap_shift_t {data[31:0], regselect, size[1:0], addrinc, r_w}.
- cmd_ready  out  1  controller idle; a command is accepted when cmd_valid & cmd_ready.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  32  read result; held until the next rsp_valid.
- rsp_err  out  1  completion carried an error; valid with rsp_valid.
- err_sticky  out  1  sticky error flag.
- err_clear  in  1  clears err_sticky.
- HADDR  out  32;  HWRITE  out  1;  HSIZE  out  3;  HTRANS  out  2;  HWDATA  out  32.
- HRDATA  in  32;  HREADY  in  1;  HRESP  in  1.

Behaviour:
- Reset values: cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, err_sticky=0, HTRANS=IDLE(00), HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0, address register=ADDR_RESET, state=IDLE.
- RST mid-transfer returns to IDLE immediately and emits no rsp_valid. Aborting a bus transfer is accepted for debug reset.
- States: IDLE, ADDR, DATA, ERR2, RESP.
- IDLE:
  - cmd_ready=1. On accept, regselect=ADDRESS:
    - WRITE: address register <= cmd.data.
    - READ: rsp_data <= address register.
    - Either case goes to RESP with rsp_err=0 and generates no bus traffic.
  - On accept, regselect=DATA:
    - Checks, in this order: (a) err_sticky=1, (b) size=2'b11, (c) misalignment (HALFWORD with addr[0]=1; WORD with addr[1:0]!=0).
    - If any check fails: no bus traffic, go to RESP with rsp_err=1, and set err_sticky for (b) and (c).
    - Otherwise go to ADDR.
- ADDR:
  - Drives HTRANS=NONSEQ(10), HADDR=address register, HWRITE=r_w, HSIZE={1'b0,size}.
  - Holds these until HREADY=1, then goes to DATA.
- DATA:
  - Drives HTRANS=IDLE.
  - HWDATA replicates the data lanes: BYTE -> {4{data[7:0]}}, HALFWORD -> {2{data[15:0]}}, WORD -> data.
  - HREADY=1 & HRESP=0: go to RESP. For a read, rsp_data <= the selected lane shifted to bits [7:0]/[15:0] and zero-extended. If addrinc=1, address register += (1<<size), with 32-bit wrap from FFFF_FFFF.
  - HREADY=0 & HRESP=1 (first error cycle): go to ERR2.
- ERR2:
  - Waits for HREADY=1. Sets err_sticky, rsp_err=1, and does not increment the address. Goes to RESP.
- RESP:
  - rsp_valid=1 for exactly one cycle, cmd_ready=0, then IDLE.
- Latency:
  - Address-register command: rsp_valid 1 cycle after accept.
  - Zero-wait-state bus transfer: rsp_valid 3 cycles after accept.
  - Each wait state adds 1 cycle.
- err_sticky:
  - err_clear wins over a simultaneous set.
  - err_clear during an in-flight transfer does not affect that transfer's rsp_err.
- cmd_valid while cmd_ready=0 is ignored; the requester must hold it.

Decomposition:
- Add to jtag_types_pkg: ap_state_t enum (IDLE, ADDR, DATA, ERR2, RESP) and htrans_t enum (IDLE=00, NONSEQ=10).
- Reuse the existing ap_shift_t, hsize_t, regselect_t and r_w_t.
- Optional sub-module ahb_lane_steer: a combinational block for HWDATA replication and read-lane extraction, driven by size and addr[1:0].

Test Plan:
- ADDRESS write 32'h2000_0000, then ADDRESS read -> rsp_data=32'h2000_0000, rsp_err=0, HTRANS stays IDLE throughout.
- DATA WORD read at 2000_0000 with addrinc=1, HRDATA=DEADBEEF, zero wait states -> rsp_valid 3 cycles after accept, rsp_data=DEADBEEF, address becomes 2000_0004.
- DATA BYTE write data=0x5A at 2000_0003, 2 wait states -> HWDATA=5A5A5A5A, HSIZE=000, rsp_valid 5 cycles after accept.
- DATA HALFWORD read at 2000_0002 with HRDATA=1234ABCD -> rsp_data=0000_1234.
- Slave two-cycle ERROR on a write with addrinc=1 -> rsp_err=1, err_sticky=1, address unchanged. Next DATA command gives rsp_err=1 with no bus traffic. After err_clear the next command succeeds.
- WORD at 2000_0002, then size=11 -> both give rsp_err=1, err_sticky=1, HTRANS never NONSEQ. Also: RST asserted in DATA -> IDLE with all reset values, no rsp_valid.
